// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ALU opcodes and operand forward-select
// encoding for the ID/EX forwarding stage.
package pipe_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: register compares producing operand forward selects and the
// IF/ID stall; behaviour depends on HAZARD_FWD_EN.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_flush,
    input  logic              i_idex_valid,
    input  logic              i_idex_wr_en,
    input  logic              i_idex_is_load,
    input  logic [REG_AW-1:0] i_idex_rd,
    input  logic [REG_AW-1:0] i_idex_rs1,
    input  logic [REG_AW-1:0] i_idex_rs2,
    input  logic              i_exmem_valid,
    input  logic              i_exmem_wr_en,
    input  logic              i_exmem_is_load,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_memwb_valid,
    input  logic              i_memwb_wr_en,
    input  logic [REG_AW-1:0] i_memwb_rd,
    output fwd_sel_e          o_fwd_a,
    output fwd_sel_e          o_fwd_b,
    output logic              o_stall
);

    logic w_unused;

`ifdef HAZARD_FWD_EN
    logic w_ld_use;

    // Loads cannot forward from EX/MEM: their data only exists at MEM/WB.
    function automatic fwd_sel_e f_sel(input logic [REG_AW-1:0] rs);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (i_exmem_valid && i_exmem_wr_en && !i_exmem_is_load &&
                i_exmem_rd == rs)
                sel = FWD_EXMEM;
            else if (i_memwb_valid && i_memwb_wr_en && i_memwb_rd == rs)
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        o_fwd_a  = f_sel(i_idex_rs1);
        o_fwd_b  = f_sel(i_idex_rs2);
        w_ld_use = i_idex_valid && i_idex_is_load && (i_idex_rd != '0) &&
                   ((i_idex_rd == i_id_rs1) || (i_idex_rd == i_id_rs2)) &&
                   i_id_valid;
        o_stall  = w_ld_use && !i_flush;
    end

    assign w_unused = i_idex_wr_en;
`else
    function automatic logic f_busy(input logic [REG_AW-1:0] rs);
        logic hit;
        hit = (i_idex_valid && i_idex_wr_en && i_idex_rd == rs) ||
              (i_exmem_valid && i_exmem_wr_en && i_exmem_rd == rs) ||
              (i_memwb_valid && i_memwb_wr_en && i_memwb_rd == rs);
        return (rs != '0) && hit;
    endfunction

    always_comb begin
        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        o_stall = i_id_valid && !i_flush &&
                  (f_busy(i_id_rs1) || f_busy(i_id_rs2));
    end

    assign w_unused = ^{i_idex_is_load, i_exmem_is_load,
                        i_idex_rs1, i_idex_rs2};
`endif

endmodule

// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: ID/EX and EX/MEM registers, operand muxing and stall
// counter; HAZARD_FWD_EN enables forwarding and load-use-only stalls.
module id_ex_fwd_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              memwb_valid,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              stall,
    output logic              exmem_valid,
    output logic              exmem_wr_en,
    output logic              exmem_is_load,
    output logic [REG_AW-1:0] exmem_rd,
    output logic [DATA_W-1:0] exmem_result,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic              wr_en;
        logic              is_load;
    } id_ex_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
        logic              is_load;
        logic [DATA_W-1:0] result;
    } ex_mem_t;

    id_ex_t           r_idex;
    id_ex_t           w_idex_d;
    ex_mem_t          r_exmem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall;
    logic             w_take;
    fwd_sel_e         w_fwd_a;
    fwd_sel_e         w_fwd_b;

    hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_flush        (flush),
        .i_idex_valid   (r_idex.valid),
        .i_idex_wr_en   (r_idex.wr_en),
        .i_idex_is_load (r_idex.is_load),
        .i_idex_rd      (r_idex.rd),
        .i_idex_rs1     (r_idex.rs1),
        .i_idex_rs2     (r_idex.rs2),
        .i_exmem_valid  (r_exmem.valid),
        .i_exmem_wr_en  (r_exmem.wr_en),
        .i_exmem_is_load(r_exmem.is_load),
        .i_exmem_rd     (r_exmem.rd),
        .i_memwb_valid  (memwb_valid),
        .i_memwb_wr_en  (memwb_wr_en),
        .i_memwb_rd     (memwb_rd),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b),
        .o_stall        (w_stall)
    );

    // A stalled or flushed slot becomes a bubble that can never write back.
    assign w_take = id_valid && !w_stall && !flush;

    always_comb begin
        w_idex_d          = '0;
        w_idex_d.valid    = w_take;
        w_idex_d.opcode   = id_opcode;
        w_idex_d.rs1      = id_rs1;
        w_idex_d.rs2      = id_rs2;
        w_idex_d.rd       = id_rd;
        w_idex_d.rs1_data = id_rs1_data;
        w_idex_d.rs2_data = id_rs2_data;
        w_idex_d.wr_en    = id_wr_en && w_take;
        w_idex_d.is_load  = id_is_load && w_take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex  <= '0;
            r_exmem <= '0;
        end else begin
            r_idex          <= w_idex_d;
            r_exmem.valid   <= r_idex.valid;
            r_exmem.rd      <= r_idex.rd;
            r_exmem.wr_en   <= r_idex.wr_en;
            r_exmem.is_load <= r_idex.is_load;
            r_exmem.result  <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    function automatic logic [DATA_W-1:0] f_opnd(
        input logic [REG_AW-1:0] rs,
        input fwd_sel_e          sel,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] v;
        case (sel)
            FWD_EXMEM: v = r_exmem.result;
            FWD_MEMWB: v = memwb_data;
            default:   v = rf_data;
        endcase
        if (rs == '0)
            v = '0;
        return v;
    endfunction

    assign alu_a         = f_opnd(r_idex.rs1, w_fwd_a, r_idex.rs1_data);
    assign alu_b         = f_opnd(r_idex.rs2, w_fwd_b, r_idex.rs2_data);
    assign alu_opcode    = r_idex.opcode;
    assign stall         = w_stall;
    assign exmem_valid   = r_exmem.valid;
    assign exmem_wr_en   = r_exmem.wr_en;
    assign exmem_is_load = r_exmem.is_load;
    assign exmem_rd      = r_exmem.rd;
    assign exmem_result  = r_exmem.result;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: doc/id_ex_fwd_stage.md
# id_ex_fwd_stage

ID/EX pipeline stage with hazard detection and operand forwarding, sitting directly upstream of the 8-bit ALU.
- Registers decoded instructions from ID and drives the ALU's A, B and opcode with forwarded operands.
- Captures the ALU result into an internal EX/MEM register.
- Issues load-use stalls back to IF/ID.

## Interface
Parameters:
- DATA_W, 8, operand/result width; matches the ALU.
- REG_AW, 3, register address width (8 registers; r0 reads as zero).
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  4  ALU opcode: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111.
- id_rs1, id_rs2, id_rd  in  REG_AW  source and destination registers.
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
- id_wr_en, id_is_load  in  1  writes rd / is a load.
- flush  in  1  kill the instruction entering ID/EX (branch redirect).
- memwb_valid, memwb_wr_en  in  1  MEM/WB stage state.
- memwb_rd  in  REG_AW, memwb_data  in  DATA_W  writeback target and value.
- alu_a, alu_b  out  DATA_W  forwarded operands to the ALU (combinational from the ID/EX register).
- alu_opcode  out  4  ID/EX opcode.
- alu_result  in  DATA_W  ALU result, same cycle.
- stall  out  1  hold IF/ID; combinational.
- exmem_valid, exmem_wr_en, exmem_is_load  out  1  EX/MEM register.
- exmem_rd  out  REG_AW, exmem_result  out  DATA_W  EX/MEM register.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- ID/EX register holds valid, opcode, rs1, rs2, rd, rs1/rs2 data, wr_en and is_load.
- Each edge, ID/EX loads the ID fields with valid = id_valid & ~stall & ~flush. On stall or flush, a bubble is inserted: valid=0, wr_en=0.
- EX/MEM register loads the ID/EX valid, rd, wr_en and is_load plus alu_result every edge. There is no downstream backpressure.
- Forward select per operand, highest priority first:
  - EX/MEM, if exmem_valid & exmem_wr_en & ~exmem_is_load & exmem_rd==rs & rs!=0.
  - MEM/WB, if memwb_valid & memwb_wr_en & memwb_rd==rs & rs!=0.
  - Otherwise the registered register-file data.
  - rs==0 always yields 0.
- Load-use hazard: stall=1 when ID/EX valid & is_load & rd!=0 & (rd==id_rs1 | rd==id_rs2) & id_valid. Costs exactly 1 stall cycle; the dependent instruction then forwards from MEM/WB.
- Stall priority: flush forces stall=0, because the ID instruction is dead.
- stall_cnt increments on each clk edge where stall=1 and saturates at all-ones.
- Writes to r0 are never forwarded.

## Timing
- Reset values:
  - All valid, wr_en and is_load bits are 0; all data, rd and opcode fields are 0.
  - stall_cnt=0, stall=0.
  - alu_a=alu_b=0, alu_opcode=0000.
- Latency: ID to ALU inputs is 1 cycle; ALU result to exmem_result is 1 cycle.
- Reset asserted mid-operation clears all in-flight instructions immediately; no partial writeback is emitted.
- Simultaneous stall and flush: flush wins and a bubble is inserted.

## Configuration
- HAZARD_FWD_EN defined: forwarding and load-use stall operate as described.
- HAZARD_FWD_EN undefined: no forwarding; alu_a/alu_b are always the registered register-file data.
  - stall=1 whenever an ID source (nonzero) matches the rd of any valid writing instruction in ID/EX, EX/MEM or MEM/WB.
  - A dependent instruction immediately after its producer therefore stalls 3 cycles.

## Structure
- Package pipe_pkg holds:
  - DATA_W, REG_AW.
  - Opcode localparams OP_ADD..OP_SRL.
  - Forward-select enum FWD_RF / FWD_EXMEM / FWD_MEMWB.
- One combinational sub-module, hazard_unit, does the register compares and produces the per-operand forward selects and stall. The pipeline registers and the counter stay in id_ex_fwd_stage.

## Test plan
- Reset held mid-stream with three instructions in flight: all valids drop to 0 at once and stall_cnt=0; after release, the first new instruction appears at the ALU one cycle later.
- ADD r1=5+3 followed by SUB r2=r1-r4 (r4=2): SUB sees alu_a=8 from EX/MEM, alu_b=2, alu_result=6, and no stall.
- LOAD r2 followed by ADD r3=r2+r1: stall=1 for 1 cycle and a bubble in EX; ADD takes alu_a=memwb_data (0x2A), and stall_cnt=1.
- EX/MEM writes r4=0x11 while MEM/WB writes r4=0x22, and the instruction uses r4: alu_a=0x11.
- Producer with rd=r0 result 0x55, then a consumer of r0: alu_a=0 and no forward.
- flush together with a load-use condition: stall=0, a bubble is inserted, and stall_cnt is unchanged.
- Build without HAZARD_FWD_EN, ADD r1 then XOR r5=r1^r1: 3 stall cycles, then alu_a=alu_b equal to the register-file value, and stall_cnt=3.
